// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_tx_state_t : frame sequencing states (IDLE, START, DATA, STOP)
//   START_BIT       : line level during the start bit
//   STOP_BIT        : line level during the stop bit
//   IDLE_LEVEL      : line level between frames
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-in, serial-out shift register, LSB first.
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-high; contents become all 1s
//   load       : capture d (has priority over shift)
//   shift      : shift right by one, filling the MSB with 1
//   d          : parallel load value
//   serial_out : current LSB (the bit on the line now)
//   next_out   : the bit that becomes the LSB after the next shift
module flex_pts_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             serial_out,
  output logic             next_out
);

  logic [WIDTH-1:0] q;

  // Filling with 1s means an over-shifted register reads as idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '1;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b1, q[WIDTH-1:1]};
    end
  end

  assign serial_out = q[0];

  // Exposed so the owner can register the post-shift line level on the same
  // edge that performs the shift.
  if (WIDTH > 1) begin : g_next
    assign next_out = q[1];
  end else begin : g_next_fill
    assign next_out = 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1: start bit (0), DATA_BITS data bits LSB first,
// stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-high
//   tx_start : send request; honoured in IDLE and on the final stop-bit edge
//   tx_data  : byte to send, captured on the accepting edge
//   tx_out   : registered serial line, idles high
//   tx_busy  : registered, high while a frame is on the line
//   tx_done  : registered one-cycle pulse in the cycle after the stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  uart_tx_state_t state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [BW-1:0]  bit_idx, bit_d;
  logic           out_d, busy_d, done_d;
  logic           sr_load, sr_shift, sr_lsb, sr_next;
  logic           cnt_last, bit_last;

  assign cnt_last = (cnt == CW'(CLKS_PER_BIT - 1));
  assign bit_last = (bit_idx == BW'(DATA_BITS - 1));

  flex_pts_sr #(
    .WIDTH (DATA_BITS)
  ) u_sr (
    .clk        (clk),
    .rst        (rst),
    .load       (sr_load),
    .shift      (sr_shift),
    .d          (tx_data),
    .serial_out (sr_lsb),
    .next_out   (sr_next)
  );

  // Outputs are computed from the next state so they can be registered
  // without a cycle of lag: the line level after an edge is decided before it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    bit_d    = bit_idx;
    out_d    = tx_out;
    busy_d   = tx_busy;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    unique case (state)
      IDLE: begin
        out_d  = IDLE_LEVEL;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d = START;
          cnt_d   = '0;
          sr_load = 1'b1;
          out_d   = START_BIT;
          busy_d  = 1'b1;
        end
      end

      START: begin
        busy_d = 1'b1;
        out_d  = START_BIT;
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          out_d   = sr_lsb;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      DATA: begin
        busy_d = 1'b1;
        out_d  = sr_lsb;
        if (cnt_last) begin
          cnt_d    = '0;
          sr_shift = 1'b1;
          if (bit_last) begin
            state_d = STOP;
            out_d   = STOP_BIT;
          end else begin
            bit_d = bit_idx + BW'(1);
            out_d = sr_next;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      STOP: begin
        busy_d = 1'b1;
        out_d  = STOP_BIT;
        if (cnt_last) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // The final stop-bit edge doubles as the first IDLE sampling edge,
          // so a waiting request chains the next frame with no idle gap.
          if (tx_start) begin
            state_d = START;
            sr_load = 1'b1;
            out_d   = START_BIT;
          end else begin
            state_d = IDLE;
            out_d   = IDLE_LEVEL;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_out  <= IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      tx_out  <= out_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (CLKS_PER_BIT = 10, 2, 16)
// share clock and reset. Expected line levels come from the frame rule
// "bit n of {stop, data, start} holds for CLKS_PER_BIT cycles".
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [7:0] data_v [3];
  logic [2:0] out_v, busy_v, done_v;

  int cpb_of [3] = '{10, 2, 16};
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut10 (
    .clk(clk), .rst(rst), .tx_start(start_v[0]), .tx_data(data_v[0]),
    .tx_out(out_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut2 (
    .clk(clk), .rst(rst), .tx_start(start_v[1]), .tx_data(data_v[1]),
    .tx_out(out_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut16 (
    .clk(clk), .rst(rst), .tx_start(start_v[2]), .tx_data(data_v[2]),
    .tx_out(out_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [9:0] exp_bits;  // line bits in time order, LSB = start bit
    int         exp_len;   // frame length in cycles
    int         poke;      // cycle to pulse tx_start=1 with 0xFF (0 = none)
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Send one byte on instance k and check every cycle of the frame, the
  // tx_done cycle, and a quiet line afterwards.
  task automatic send_check(input int k, input logic [7:0] d,
                            input logic [9:0] bits, input int len,
                            input int poke, input string tag);
    int cpb = cpb_of[k];
    int out_bad = 0, busy_bad = 0, done_bad = 0, post_bad = 0;
    @(negedge clk);
    data_v[k]  = d;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    data_v[k]  = 8'($urandom);
    for (int c = 1; c <= len; c++) begin
      if (c == poke) begin
        start_v[k] = 1'b1;
        data_v[k]  = 8'hFF;
      end else if (c == poke + 1) begin
        start_v[k] = 1'b0;
      end
      if (out_v[k] !== bits[(c-1)/cpb]) out_bad++;
      if (busy_v[k] !== 1'b1) busy_bad++;
      if (done_v[k] !== 1'b0) done_bad++;
      @(negedge clk);
    end
    check({tag, " line levels"}, out_bad, 0);
    check({tag, " busy during frame"}, busy_bad, 0);
    check({tag, " no early done"}, done_bad, 0);
    check({tag, " done pulse"}, int'(done_v[k]), 1);
    check({tag, " busy fall"}, int'(busy_v[k]), 0);
    check({tag, " idle after stop"}, int'(out_v[k]), 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_v[k] !== 1'b0 || out_v[k] !== 1'b1 || busy_v[k] !== 1'b0) post_bad++;
    end
    check({tag, " quiet after frame"}, post_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) data_v[k] = 8'h00;

    vecs[0] = '{inst: 0, data: 8'hA5, exp_bits: 10'b1101001010, exp_len: 100, poke: 0};
    vecs[1] = '{inst: 0, data: 8'h3C, exp_bits: 10'b1001111000, exp_len: 100, poke: 40};
    vecs[2] = '{inst: 1, data: 8'h5A, exp_bits: 10'b1010110100, exp_len: 20,  poke: 0};
    vecs[3] = '{inst: 2, data: 8'h5A, exp_bits: 10'b1010110100, exp_len: 160, poke: 0};

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out[%0d]", k),  int'(out_v[k]),  1);
      check($sformatf("reset busy[%0d]", k), int'(busy_v[k]), 0);
      check($sformatf("reset done[%0d]", k), int'(done_v[k]), 0);
    end
    rst = 1'b0;

    // Table-driven frames
    foreach (vecs[i])
      send_check(vecs[i].inst, vecs[i].data, vecs[i].exp_bits,
                 vecs[i].exp_len, vecs[i].poke, $sformatf("vec%0d", i));

    // Back-to-back: tx_start held, 0x00 then 0x81, no idle cycle between
    begin
      int out_bad = 0, busy_bad = 0, done_bad = 0;
      @(negedge clk);
      data_v[0]  = 8'h00;
      start_v[0] = 1'b1;
      @(negedge clk);
      data_v[0]  = 8'h81;
      for (int c = 1; c <= 200; c++) begin
        logic [9:0] f;
        int         b;
        if (c == 150) start_v[0] = 1'b0;
        f = (c <= 100) ? frame_of(8'h00) : frame_of(8'h81);
        b = (c <= 100) ? (c - 1) / 10 : (c - 101) / 10;
        if (out_v[0] !== f[b]) out_bad++;
        if (busy_v[0] !== 1'b1) busy_bad++;
        if (done_v[0] !== (c == 101)) done_bad++;
        @(negedge clk);
      end
      check("b2b line levels", out_bad, 0);
      check("b2b busy", busy_bad, 0);
      check("b2b done timing", done_bad, 0);
      check("b2b second done", int'(done_v[0]), 1);
      check("b2b busy fall", int'(busy_v[0]), 0);
    end

    // Asynchronous reset inside START and inside DATA of a 0xFF frame
    foreach (cpb_of[r]) begin
      int rc, idle_bad;
      if (r == 2) break;
      rc = (r == 0) ? 5 : 35;
      idle_bad = 0;
      @(negedge clk);
      data_v[0]  = 8'hFF;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (rc - 1) @(negedge clk);
      check($sformatf("pre-reset busy @%0d", rc), int'(busy_v[0]), 1);
      #2 rst = 1'b1;
      #1;
      check($sformatf("async reset out @%0d", rc),  int'(out_v[0]),  1);
      check($sformatf("async reset busy @%0d", rc), int'(busy_v[0]), 0);
      check($sformatf("async reset done @%0d", rc), int'(done_v[0]), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) idle_bad++;
      end
      check($sformatf("no residual frame @%0d", rc), idle_bad, 0);
    end

    // Loopback: random bytes decoded by a mid-bit sampling receiver model
    for (int i = 0; i < 16; i++) begin
      int         k = i % 3;
      int         cpb = cpb_of[k];
      int         len = 10 * cpb;
      int         done_at = -1;
      logic [7:0] d = 8'($urandom);
      logic [9:0] rx = '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      data_v[k]  = d;
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      for (int c = 1; c <= len; c++) begin
        if ((c - 1) % cpb == cpb / 2) rx[(c - 1) / cpb] = out_v[k];
        @(negedge clk);
      end
      for (int w = 0; w < 6 && done_at < 0; w++) begin
        if (done_v[k] === 1'b1) done_at = len + 1 + w;
        else @(negedge clk);
      end
      check($sformatf("loopback start bit #%0d", i), int'(rx[0]), 0);
      check($sformatf("loopback byte #%0d", i),      int'(rx[8:1]), int'(d));
      check($sformatf("loopback stop bit #%0d", i),  int'(rx[9]), 1);
      check($sformatf("loopback done cycle #%0d", i), done_at, len + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
